lcu_adder16: RTL and testbench

LCU_ADDER16 -- requirements
Module: lcu_adder16

---
 rtl/lcu_adder16_pkg.sv | 10 +
 rtl/lcu4.sv | 27 ++
 rtl/lcu_adder16.sv | 92 +++++++++
 tb/tb_lcu_adder16.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lcu_adder16_pkg.sv
// Shared constants for the 16-bit two-level carry-lookahead adder.
//   ADD_W : datapath width
//   GRP_W : width of one lookahead group (bits per lcu4 unit)
package lcu_adder16_pkg;

  localparam int unsigned ADD_W = 16;
  localparam int unsigned GRP_W = 4;
  localparam int unsigned N_GRP = ADD_W / GRP_W;

endpackage : lcu_adder16_pkg

// File: rtl/lcu4.sv
// 4-bit carry-lookahead unit. The same unit serves two levels: over per-bit
// propagate/generate, or over the group P/G of four lower-level units.
// Ports:
//   p[3:0], g[3:0] : propagate / generate inputs
//   ci             : carry into position 0
//   c[3:1]         : carries into positions 1..3, fully expanded
//   gp, gg         : group propagate / group generate (independent of ci)
module lcu4
  import lcu_adder16_pkg::*;
(
  input  logic [GRP_W-1:0] p,
  input  logic [GRP_W-1:0] g,
  input  logic             ci,
  output logic [GRP_W-1:1] c,
  output logic             gp,
  output logic             gg
);

  always_comb begin
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule : lcu4

// File: rtl/lcu_adder16.sv
// 16-bit adder built from two levels of 4-bit carry lookahead, with all
// outputs registered (one-cycle latency, one operand set per cycle).
// Ports:
//   clk   : rising-edge clock for the output registers
//   rst_n : asynchronous active-low reset, clears all outputs
//   a, b  : 16-bit unsigned addends
//   cin   : carry into bit 0
//   sum   : registered (a + b + cin) mod 2^16
//   cout  : registered carry out of bit 15
//   pg    : registered group propagate over all 16 bits
//   gg    : registered group generate over all 16 bits
module lcu_adder16
  import lcu_adder16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum,
  output logic             cout,
  output logic             pg,
  output logic             gg
);

  logic [ADD_W-1:0] p;
  logic [ADD_W-1:0] g;
  logic [ADD_W:0]   c;
  logic [N_GRP-1:0] grp_p;
  logic [N_GRP-1:0] grp_g;
  logic [N_GRP-1:1] grp_c;
  logic             blk_p;
  logic             blk_g;

  logic [ADD_W-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             pg_q, gg_q;

  assign p = a ^ b;
  assign g = a & b;

  // First level: one unit per 4-bit slice, fed by the second-level carries.
  for (genvar k = 0; k < N_GRP; k++) begin : g_grp
    lcu4 u_lcu4 (
      .p  (p[k*GRP_W +: GRP_W]),
      .g  (g[k*GRP_W +: GRP_W]),
      .ci (c[k*GRP_W]),
      .c  (c[k*GRP_W+1 +: GRP_W-1]),
      .gp (grp_p[k]),
      .gg (grp_g[k])
    );
  end

  // Second level: carries into each slice, computed directly from cin.
  lcu4 u_lcu4_top (
    .p  (grp_p),
    .g  (grp_g),
    .ci (cin),
    .c  (grp_c),
    .gp (blk_p),
    .gg (blk_g)
  );

  assign c[0]         = cin;
  assign c[GRP_W]     = grp_c[1];
  assign c[2*GRP_W]   = grp_c[2];
  assign c[3*GRP_W]   = grp_c[3];
  assign c[ADD_W]     = blk_g | (blk_p & cin);

  assign sum_d  = p ^ c[ADD_W-1:0];
  assign cout_d = c[ADD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      pg_q   <= blk_p;
      gg_q   <= blk_g;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign pg   = pg_q;
  assign gg   = gg_q;

endmodule : lcu_adder16

// File: tb/tb_lcu_adder16.sv
// Self-checking bench for lcu_adder16: directed table, random vectors against
// an arithmetic reference model, a Fibonacci sweep and a mid-stream reset.
module tb_lcu_adder16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        pg;
  logic        gg;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        pg;
    logic        gg;
  } vec_t;

  vec_t vecs[7];

  lcu_adder16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .pg    (pg),
    .gg    (gg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition. pg means a+b is all ones with no
  // carry; gg means a+b overflows 16 bits without help from cin.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin,
                       output logic [15:0] es, output logic ec, output logic ep,
                       output logic eg);
    int unsigned total;
    int unsigned raw;
    total = int'(ma) + int'(mb) + int'(mcin);
    raw   = int'(ma) + int'(mb);
    es = total[15:0];
    ec = (total >= 32'd65536);
    eg = (raw >= 32'd65536);
    ep = (raw == 32'd65535);
  endtask

  task automatic check(input string name, input logic [15:0] es, input logic ec,
                       input logic ep, input logic eg);
    checks++;
    if (sum !== es || cout !== ec || pg !== ep || gg !== eg) begin
      failures++;
      $display("FAIL %s: got sum=%h cout=%b pg=%b gg=%b, want sum=%h cout=%b pg=%b gg=%b",
               name, sum, cout, pg, gg, es, ec, ep, eg);
    end
  endtask

  // Drive operands, clock once, sample just after the edge.
  task automatic apply(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_model(input string name, input logic [15:0] va, input logic [15:0] vb,
                             input logic vc);
    logic [15:0] es;
    logic        ec, ep, eg;
    model(va, vb, vc, es, ec, ep, eg);
    apply(va, vb, vc);
    check(name, es, ec, ep, eg);
  endtask

  // Assert reset between edges with a fresh operand set in flight, confirm
  // async clear and that the in-flight result is dropped, then release.
  task automatic mid_reset(input logic [15:0] va, input logic [15:0] vb);
    a   = 16'h1234;
    b   = 16'h4321;
    cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_discard", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    apply_model("reset_first_edge", va, vb, 1'b0);
  endtask

  initial begin
    logic [15:0] fa, fb, nb;
    int          step;

    checks   = 0;
    failures = 0;
    a        = 16'h0000;
    b        = 16'h0000;
    cin      = 1'b0;
    rst_n    = 1'b1;

    vecs[0] = '{a: 16'h0000, b: 16'hFFFF, cin: 1'b0, sum: 16'hFFFF, cout: 1'b0, pg: 1'b1, gg: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b0, sum: 16'hFFFF, cout: 1'b0, pg: 1'b1, gg: 1'b0};
    vecs[2] = '{a: 16'h0000, b: 16'hFFFF, cin: 1'b1, sum: 16'h0000, cout: 1'b1, pg: 1'b1, gg: 1'b0};
    vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1, pg: 1'b0, gg: 1'b1};
    vecs[4] = '{a: 16'h0001, b: 16'hFFFF, cin: 1'b0, sum: 16'h0000, cout: 1'b1, pg: 1'b0, gg: 1'b1};
    vecs[5] = '{a: 16'h0001, b: 16'hFFFF, cin: 1'b1, sum: 16'h0001, cout: 1'b1, pg: 1'b0, gg: 1'b1};
    vecs[6] = '{a: 16'h00F0, b: 16'h0F0F, cin: 1'b0, sum: 16'h0FFF, cout: 1'b0, pg: 1'b0, gg: 1'b0};

    #2;
    rst_n = 1'b0;
    #1;
    check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
    // Release away from the edge; first edge must load the present inputs.
    a     = 16'h0000;
    b     = 16'hFFFF;
    cin   = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_reset", 16'h0000, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].pg, vecs[i].gg);
    end

    // Back-to-back random operands: a check every cycle also proves no bubbles.
    for (int i = 0; i < 200; i++) begin
      apply_model($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Pure propagate chains with random cin stress the longest carry path.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      apply_model($sformatf("prop%0d", i), r, ~r, 1'($urandom));
    end

    // Fibonacci sweep, with a reset thrown in partway through.
    fa   = 16'd0;
    fb   = 16'd1;
    step = 0;
    while (fa < 16'd1024) begin
      if (step == 8) mid_reset(fa, fb);
      else apply_model($sformatf("fib%0d", step), fa, fb, 1'b0);
      if (cout !== 1'b0) begin
        failures++;
        $display("FAIL fib_cout%0d: got cout=%b, want 0", step, cout);
      end
      checks++;
      nb   = fa + fb;
      fa   = fb;
      fb   = nb;
      step++;
      if (step > 100) begin
        failures++;
        checks++;
        $display("FAIL fib_bound: sweep ran %0d steps, want fewer than 100", step);
        break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, want finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_lcu_adder16
